flag_empty_ctrl: RTL and testbench
==================================

// Module: flag_empty_ctrl
// PURPOSE
// - Read-domain pointer and flag controller for the async (CDC) FIFO; next generation of the empty-flag block.
// - Owns the read pointer (binary and Gray) and takes the write Gray pointer after the 2-FF synchroniser.
// - Produces look-ahead empty, a fill level, almost_empty and a sticky underflow error.
// - Sits between the read-side user logic and the dual-port RAM read address.
// PARAMETERS
// - ADDRSIZE  default 8   RAM address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
// - AE_LEVEL  default 4   almost_empty asserts when the fill level is <= AE_LEVEL; legal range 0..2**ADDRSIZE.
// PORTS
// - clk        in   1           read-domain clock; all state updates on posedge.
// - rst        in   1           synchronous reset, active-high.
// - rd_en      in   1           read request from the user.
// - q2_wptr    in   ADDRSIZE+1  write pointer (Gray) after the 2-FF synchroniser.
// - err_clr    in   1           clears underflow.
// - rptr       out  ADDRSIZE+1  read pointer (Gray), registered; goes to the write-domain synchroniser.
// - raddr      out  ADDRSIZE    RAM read address = rbin[ADDRSIZE-1:0].
// - empty      out  1           FIFO empty, registered.
// - almost_empty out 1          fill level <= AE_LEVEL, registered.
// - rd_level   out  ADDRSIZE+1  fill level seen from the read side, range 0..2**ADDRSIZE, registered.
// - underflow  out  1           sticky: a read was attempted while empty.
// BEHAVIOUR
// - Reset values (rst=1 at a posedge):
//   - rbin=0, rptr=0, raddr=0, rd_level=0, underflow=0.
//   - empty=1, almost_empty=1.
//   - rst has priority over every other input.
// - Accepted read: rinc = rd_en & ~empty.
//   - While empty, rd_en has no effect on any pointer.
// - Next-state values:
//   - rbin_next = rbin + rinc (mod 2**(ADDRSIZE+1)).
//   - rgray_next = (rbin_next>>1) ^ rbin_next.
//   - Each posedge: rbin<=rbin_next, rptr<=rgray_next.
// - Empty look-ahead: empty <= (rgray_next == q2_wptr).
//   - The read that takes the last word sets empty at that same edge.
//   - No extra cycle of latency.
// - Write pointer decode: wbin_s = gray2bin(q2_wptr), combinational, XOR-prefix from the MSB.
// - Fill level: rd_level <= wbin_s - rbin_next, mod 2**(ADDRSIZE+1), no saturation.
//   - Equal MSB with equal remaining bits gives 0.
//   - Differing MSB with equal remaining bits gives 2**ADDRSIZE (full).
// - almost_empty <= (level_next <= AE_LEVEL), where level_next is the value being loaded into rd_level.
// - Latency:
//   - A q2_wptr change shows on empty, rd_level and almost_empty one clk later.
//   - Levels are pessimistic by the synchroniser delay; that is intended.
// - Underflow:
//   - underflow <= underflow | (rd_en & empty) when err_clr=0.
//   - underflow <= (rd_en & empty) when err_clr=1, so set beats clear in the same cycle.
// - Wrap-around:
//   - rbin rolls over from 2**(ADDRSIZE+1)-1 to 0.
//   - raddr rolls over from 2**ADDRSIZE-1 to 0.
//   - The MSB of the pointer tells full and empty apart.
// - rptr changes by exactly one Gray bit per accepted read; it never changes by more.
// TESTING
// - Reset: hold rst 2 cycles with rd_en=1 and q2_wptr=5.
//   -> empty=1, almost_empty=1, rptr=0, raddr=0, rd_level=0, underflow=0.
// - Level/AE (AE_LEVEL=4): drive q2_wptr=gray(3)=3'b010 with no reads.
//   -> next cycle empty=0, rd_level=3, almost_empty=1.
//   - Then q2_wptr=gray(8)=4'b1100 -> rd_level=8, almost_empty=0.
// - Drain: q2_wptr=gray(3), rd_en=1 for 4 cycles.
//   -> raddr runs 0,1,2; empty=1 at the edge of the 3rd read.
//   -> the 4th read leaves rptr=gray(3) and sets underflow=1; err_clr then clears it.
// - Wrap (ADDRSIZE=2): stream 10 reads against a write pointer that keeps ahead.
//   -> rbin goes 7->0 and rptr goes 3'b100->3'b000.
//   -> raddr goes 3->0; empty is correct at every step.
// - Full level (ADDRSIZE=8): rbin=0 and q2_wptr=gray(256).
//   -> rd_level=256, empty=0, almost_empty=0.
// - Reset mid-operation: assert rst while rd_level=5 and rd_en=1.
//   -> all reset values next cycle; underflow set-beats-clear checked with rd_en=1, empty=1, err_clr=1.

Source files
------------

// File: rtl/flag_empty_ctrl_if.sv
// Read-side bundle of the async FIFO empty-flag controller: user read request,
// synchronised write pointer, and the pointer/flag outputs.
interface flag_empty_ctrl_if #(
    parameter int ADDRSIZE = 8
);
    logic                rd_en;
    logic [ADDRSIZE:0]   q2_wptr;
    logic                err_clr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic                empty;
    logic                almost_empty;
    logic [ADDRSIZE:0]   rd_level;
    logic                underflow;

    modport master (
        output rd_en, q2_wptr, err_clr,
        input  rptr, raddr, empty, almost_empty, rd_level, underflow
    );

    modport slave (
        input  rd_en, q2_wptr, err_clr,
        output rptr, raddr, empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/flag_empty_ctrl.sv
// Read-domain pointer and flag controller for the async FIFO: binary/Gray read
// pointer, look-ahead empty, fill level, almost_empty and sticky underflow.
module flag_empty_ctrl #(
    parameter int ADDRSIZE = 8,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst,
    flag_empty_ctrl_if.slave bus
);
    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] wbin_s;
    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic          uf_q, uf_d;
    logic          rinc;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    always_comb begin
        rinc    = bus.rd_en & ~empty_q;
        rbin_d  = rbin_q + PW'(rinc);
        rptr_d  = bin2gray(rbin_d);
        wbin_s  = gray2bin(bus.q2_wptr);
        // Modulo subtraction; the MSB difference makes a full FIFO read as 2**ADDRSIZE.
        level_d = wbin_s - rbin_d;
        empty_d = (rptr_d == bus.q2_wptr);
        ae_d    = (level_d <= AE_THR);
        // A new underflow event wins over a simultaneous clear.
        uf_d    = (bus.err_clr ? 1'b0 : uf_q) | (bus.rd_en & empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rbin_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            uf_q    <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.rptr         = rptr_q;
    assign bus.raddr        = rbin_q[ADDRSIZE-1:0];
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.rd_level     = level_q;
    assign bus.underflow    = uf_q;
endmodule

// File: tb/tb_flag_empty_ctrl.sv
// Directed bench for flag_empty_ctrl: a deep instance (ADDRSIZE=8) for reset,
// level, drain and underflow, and a shallow one (ADDRSIZE=2) for wrap-around.
module tb_flag_empty_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    flag_empty_ctrl_if #(.ADDRSIZE(8)) bus_a ();
    flag_empty_ctrl_if #(.ADDRSIZE(2)) bus_b ();

    flag_empty_ctrl #(.ADDRSIZE(8), .AE_LEVEL(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    flag_empty_ctrl #(.ADDRSIZE(2), .AE_LEVEL(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] g9(input int b);
        logic [8:0] x;
        x = b[8:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [2:0] g3(input int b);
        logic [2:0] x;
        x = b[2:0];
        return x ^ (x >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_reset(input string tag);
        check_eq({tag, ".empty"}, 32'(bus_a.empty), 32'd1);
        check_eq({tag, ".ae"},    32'(bus_a.almost_empty), 32'd1);
        check_eq({tag, ".rptr"},  32'(bus_a.rptr), 32'd0);
        check_eq({tag, ".raddr"}, 32'(bus_a.raddr), 32'd0);
        check_eq({tag, ".level"}, 32'(bus_a.rd_level), 32'd0);
        check_eq({tag, ".uf"},    32'(bus_a.underflow), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus_a.rd_en = 1'b1; bus_a.q2_wptr = 9'd5; bus_a.err_clr = 1'b0;
        bus_b.rd_en = 1'b0; bus_b.q2_wptr = 3'd0; bus_b.err_clr = 1'b0;

        // Reset held two cycles with a read request and non-zero write pointer
        tick(); tick();
        check_a_reset("rst");

        // Level and almost_empty
        rst = 1'b0; bus_a.rd_en = 1'b0; bus_a.q2_wptr = g9(3);
        tick();
        check_eq("lvl3.empty", 32'(bus_a.empty), 32'd0);
        check_eq("lvl3.level", 32'(bus_a.rd_level), 32'd3);
        check_eq("lvl3.ae",    32'(bus_a.almost_empty), 32'd1);
        bus_a.q2_wptr = g9(8);
        tick();
        check_eq("lvl8.level", 32'(bus_a.rd_level), 32'd8);
        check_eq("lvl8.ae",    32'(bus_a.almost_empty), 32'd0);

        // Drain three words, then one read while empty
        bus_a.q2_wptr = g9(3); bus_a.rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("drain%0d.raddr", k), 32'(bus_a.raddr), k);
            tick();
            check_eq($sformatf("drain%0d.empty", k), 32'(bus_a.empty), (k == 2) ? 1 : 0);
            check_eq($sformatf("drain%0d.level", k), 32'(bus_a.rd_level), 2 - k);
            check_eq($sformatf("drain%0d.rptr", k),  32'(bus_a.rptr), 32'(g9(k + 1)));
        end
        check_eq("drain.ae", 32'(bus_a.almost_empty), 32'd1);
        tick();
        check_eq("uread.rptr",  32'(bus_a.rptr), 32'(g9(3)));
        check_eq("uread.raddr", 32'(bus_a.raddr), 32'd3);
        check_eq("uread.uf",    32'(bus_a.underflow), 32'd1);
        check_eq("uread.empty", 32'(bus_a.empty), 32'd1);
        bus_a.rd_en = 1'b0;
        tick();
        check_eq("uf.sticky", 32'(bus_a.underflow), 32'd1);
        bus_a.err_clr = 1'b1;
        tick();
        check_eq("uf.clr", 32'(bus_a.underflow), 32'd0);
        bus_a.err_clr = 1'b0;

        // Full level: write pointer one lap ahead of rbin=0
        rst = 1'b1;
        tick();
        rst = 1'b0; bus_a.q2_wptr = g9(256);
        tick();
        check_eq("full.level", 32'(bus_a.rd_level), 32'd256);
        check_eq("full.empty", 32'(bus_a.empty), 32'd0);
        check_eq("full.ae",    32'(bus_a.almost_empty), 32'd0);

        // Reset in the middle of operation
        bus_a.q2_wptr = g9(5);
        tick();
        check_eq("mid.level", 32'(bus_a.rd_level), 32'd5);
        rst = 1'b1; bus_a.rd_en = 1'b1;
        tick();
        check_a_reset("midrst");

        // Set beats clear while empty
        rst = 1'b0; bus_a.q2_wptr = 9'd0; bus_a.err_clr = 1'b1;
        tick();
        check_eq("sbc.uf",   32'(bus_a.underflow), 32'd1);
        check_eq("sbc.rptr", 32'(bus_a.rptr), 32'd0);
        bus_a.rd_en = 1'b0;
        tick();
        check_eq("sbc.clr", 32'(bus_a.underflow), 32'd0);
        bus_a.err_clr = 1'b0;

        // Wrap-around on the shallow instance: write pointer stays two ahead
        bus_b.q2_wptr = g3(2);
        tick();
        check_eq("wprime.empty", 32'(bus_b.empty), 32'd0);
        check_eq("wprime.level", 32'(bus_b.rd_level), 32'd2);
        bus_b.rd_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus_b.q2_wptr = g3(k + 2);
            check_eq($sformatf("wrap%0d.raddr_pre", k), 32'(bus_b.raddr), k % 4);
            tick();
            check_eq($sformatf("wrap%0d.rptr", k),  32'(bus_b.rptr), 32'(g3(k + 1)));
            check_eq($sformatf("wrap%0d.empty", k), 32'(bus_b.empty), 32'd0);
            check_eq($sformatf("wrap%0d.level", k), 32'(bus_b.rd_level), 32'd1);
            check_eq($sformatf("wrap%0d.ae", k),    32'(bus_b.almost_empty), 32'd1);
        end
        bus_b.rd_en = 1'b1; bus_b.q2_wptr = g3(11);
        tick();
        check_eq("wend.empty", 32'(bus_b.empty), 32'd1);
        check_eq("wend.rptr",  32'(bus_b.rptr), 32'(g3(11)));
        check_eq("wend.raddr", 32'(bus_b.raddr), 32'd3);
        bus_b.rd_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
